// File: rtl/lsu_mem_stage_pkg.sv
// Shared configuration, ISA and CPU types for the load/store unit, plus the
// lane/alignment helpers used when an op is accepted.
package cpu_config;
    localparam int XLEN = 32;
endpackage

package riscv_types;
    typedef logic [4:0] rs_addr_t;
endpackage

package cpu_types;
    typedef enum logic [2:0] {
        LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_REQ, ST_RESP
    } lsu_state_t;
endpackage

package lsu_mem_stage_pkg;
    import cpu_config::*;
    import cpu_types::*;

    function automatic logic lsu_is_load(input lsu_op_t op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic lsu_misaligned(input lsu_op_t op, input logic [1:0] off);
        logic bad;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: bad = off[0];
            LSU_LW, LSU_SW:          bad = |off;
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [XLEN/8-1:0] lsu_byte_en(input lsu_op_t op, input logic [1:0] off);
        logic [XLEN/8-1:0] be;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << off;
            LSU_LH, LSU_LHU, LSU_SH: be = 4'b0011 << off;
            default:                 be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated so every candidate lane carries it; be selects.
    function automatic logic [XLEN-1:0] lsu_store_data(input lsu_op_t op, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] lanes;
        case (op)
            LSU_SB:  lanes = {4{data[7:0]}};
            LSU_SH:  lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction
endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Extracts the addressed byte/halfword/word from a bus word and extends it.
module lsu_load_align
    import cpu_config::*, cpu_types::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  lsu_op_t         op,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (op)
            LSU_LB:  result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LSU_LBU: result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LSU_LH:  result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LSU_LHU: result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: one outstanding bus access at a time,
// with alignment checks, a per-access timeout and flush-driven writeback kill.
module lsu_mem_stage
    import cpu_config::*, riscv_types::*, cpu_types::*, lsu_mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  lsu_op_t           in_op,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  rs_addr_t          in_rd_addr,
    input  logic              in_rd_en,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic              dmem_err,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [XLEN-1:0]   lsu_res,
    output logic              lsu_res_en,
    output rs_addr_t          rd_addr_o,
    output logic              rd_en_o,
    output logic              misalign_o,
    output logic              bus_err_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    lsu_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              kill_q;
    lsu_op_t           op_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN/8-1:0] be_q;
    rs_addr_t          rd_q;
    logic              rd_en_q;
    logic              accept;
    logic              timeout;
    logic              wb_ok;
    logic [XLEN-1:0]   load_res;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready && !flush;
    assign timeout  = (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign wb_ok    = lsu_is_load(op_q) && rd_en_q && (rd_q != '0) && !kill_q && !flush;

    // Bus request fields come straight from the latched op and are held until gnt.
    assign dmem_req   = (state == ST_REQ);
    assign dmem_we    = dmem_req && !lsu_is_load(op_q);
    assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be_q : '0;
    assign dmem_wdata = dmem_req ? wdata_q : '0;

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .op     (op_q),
        .result (load_res)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= in_op;
            addr_q  <= in_addr;
            wdata_q <= lsu_store_data(in_op, in_wdata);
            be_q    <= lsu_byte_en(in_op, in_addr[1:0]);
            rd_q    <= in_rd_addr;
            rd_en_q <= in_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            kill_q     <= 1'b0;
            lsu_res    <= '0;
            lsu_res_en <= 1'b0;
            rd_addr_o  <= '0;
            rd_en_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            lsu_res_en <= 1'b0;
            rd_en_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (lsu_misaligned(in_op, in_addr[1:0])) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state    <= ST_REQ;
                            wait_cnt <= '0;
                            kill_q   <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A grant wins over a coincident flush: the response must still be drained.
                    if (dmem_gnt) begin
                        state <= ST_RESP;
                        if (flush) kill_q <= 1'b1;
                    end else if (flush) begin
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        bus_err_o <= 1'b1;
                    end
                end
                ST_RESP: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (dmem_rvalid) begin
                        state <= ST_IDLE;
                        if (dmem_err) begin
                            bus_err_o <= 1'b1;
                        end else if (wb_ok) begin
                            lsu_res    <= load_res;
                            lsu_res_en <= 1'b1;
                            rd_addr_o  <= rd_q;
                            rd_en_o    <= 1'b1;
                        end
                    end else begin
                        if (flush) kill_q <= 1'b1;
                        if (timeout) begin
                            state     <= ST_IDLE;
                            bus_err_o <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table for single accesses plus
// hand-written timeout, flush and reset sequences.
module tb_lsu_mem_stage;
    import cpu_types::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    lsu_op_t     in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd_addr;
    logic        in_rd_en;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic        dmem_err;
    logic [31:0] dmem_rdata;
    logic [31:0] lsu_res;
    logic        lsu_res_en;
    logic [4:0]  rd_addr_o;
    logic        rd_en_o;
    logic        misalign_o;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.MAX_WAIT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd_addr  (in_rd_addr),
        .in_rd_en    (in_rd_en),
        .flush       (flush),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_err    (dmem_err),
        .dmem_rdata  (dmem_rdata),
        .lsu_res     (lsu_res),
        .lsu_res_en  (lsu_res_en),
        .rd_addr_o   (rd_addr_o),
        .rd_en_o     (rd_en_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        lsu_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rd;
        logic        rd_en;
        logic [3:0]  be;
        logic        we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_res;
        logic        res_en;
        logic        mis;
        logic        berr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic rd_en);
        in_valid   = 1'b1;
        in_op      = op;
        in_addr    = addr;
        in_wdata   = wdata;
        in_rd_addr = rd;
        in_rd_en   = rd_en;
    endtask

    // Entered and left on a falling edge; gnt immediate, rvalid one cycle later.
    task automatic run_vec(input vec_t v);
        start_op(v.op, v.addr, v.wdata, v.rd, v.rd_en);
        chk({v.nm, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (v.mis) begin
            chk({v.nm, " misalign_o"}, misalign_o, 1);
            chk({v.nm, " dmem_req"}, dmem_req, 0);
            chk({v.nm, " in_ready_after"}, in_ready, 1);
            @(negedge clk);
            chk({v.nm, " misalign_drop"}, misalign_o, 0);
            chk({v.nm, " dmem_req_later"}, dmem_req, 0);
        end else begin
            chk({v.nm, " misalign_o"}, misalign_o, 0);
            chk({v.nm, " dmem_req"}, dmem_req, 1);
            chk({v.nm, " dmem_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk({v.nm, " dmem_be"}, dmem_be, v.be);
            chk({v.nm, " dmem_we"}, dmem_we, v.we);
            if (v.we) chk({v.nm, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
            chk({v.nm, " req_after_gnt"}, dmem_req, 0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            dmem_err    = v.err;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_err    = 1'b0;
            chk({v.nm, " lsu_res_en"}, lsu_res_en, v.res_en);
            chk({v.nm, " rd_en_o"}, rd_en_o, v.res_en);
            chk({v.nm, " bus_err_o"}, bus_err_o, v.berr);
            if (v.res_en) begin
                chk({v.nm, " lsu_res"}, lsu_res, v.exp_res);
                chk({v.nm, " rd_addr_o"}, rd_addr_o, v.rd);
            end
            chk({v.nm, " in_ready_done"}, in_ready, 1);
            @(negedge clk);
            chk({v.nm, " res_en_drop"}, lsu_res_en, 0);
            chk({v.nm, " bus_err_drop"}, bus_err_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        //           nm            op       addr          wdata         rdata         err   rd     en    be       we    exp_wdata     exp_res       ren   mis   berr
        vecs[0]  = '{"lw_100",     LSU_LW,  32'h100, 32'h0,         32'hDEADBEEF, 1'b0, 5'd5,  1'b1, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"lb_103",     LSU_LB,  32'h103, 32'h0,         32'h80FF0000, 1'b0, 5'd6,  1'b1, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"lbu_103",    LSU_LBU, 32'h103, 32'h0,         32'h80FF0000, 1'b0, 5'd6,  1'b1, 4'b1000, 1'b0, 32'h0,        32'h00000080, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"sh_202",     LSU_SH,  32'h202, 32'h00001234,  32'h0,        1'b0, 5'd0,  1'b0, 4'b1100, 1'b1, 32'h12341234, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"lw_101_mis", LSU_LW,  32'h101, 32'h0,         32'h0,        1'b0, 5'd5,  1'b1, 4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        vecs[5]  = '{"lh_102",     LSU_LH,  32'h102, 32'h0,         32'h80017FFF, 1'b0, 5'd10, 1'b1, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"lhu_100",    LSU_LHU, 32'h100, 32'h0,         32'h8001F234, 1'b0, 5'd11, 1'b1, 4'b0011, 1'b0, 32'h0,        32'h0000F234, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"sb_301",     LSU_SB,  32'h301, 32'h000000AB,  32'h0,        1'b0, 5'd0,  1'b0, 4'b0010, 1'b1, 32'hABABABAB, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"sw_304",     LSU_SW,  32'h304, 32'hCAFEF00D,  32'h0,        1'b0, 5'd0,  1'b0, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"lw_rd0",     LSU_LW,  32'h108, 32'h0,         32'h12345678, 1'b0, 5'd0,  1'b1, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{"lw_rden0",   LSU_LW,  32'h10C, 32'h0,         32'h12345678, 1'b0, 5'd4,  1'b0, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{"lw_err",     LSU_LW,  32'h110, 32'h0,         32'h12345678, 1'b1, 5'd4,  1'b1, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vecs[12] = '{"lh_103_mis", LSU_LH,  32'h103, 32'h0,         32'h0,        1'b0, 5'd4,  1'b1, 4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        vecs[13] = '{"sw_306_mis", LSU_SW,  32'h306, 32'h11111111,  32'h0,        1'b0, 5'd0,  1'b0, 4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
        vecs[14] = '{"lb_101",     LSU_LB,  32'h101, 32'h0,         32'h00007F00, 1'b0, 5'd12, 1'b1, 4'b0010, 1'b0, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{"sw_err",     LSU_SW,  32'h314, 32'h00000001,  32'h0,        1'b1, 5'd0,  1'b0, 4'b1111, 1'b1, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_op = LSU_LW; in_addr = '0; in_wdata = '0;
        in_rd_addr = '0; in_rd_en = 1'b0; flush = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready_in_rst", in_ready, 0);
        chk("reset dmem_req", dmem_req, 0);
        chk("reset lsu_res", lsu_res, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset lsu_res_en", lsu_res_en, 0);
        chk("reset bus_err_o", bus_err_o, 0);
        chk("reset dmem_be", dmem_be, 0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Grant withheld: request stays up for exactly MAX_WAIT cycles.
        start_op(LSU_LW, 32'h400, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (dmem_req && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("timeout req_cycles", n, 255);
        chk("timeout bus_err_o", bus_err_o, 1);
        chk("timeout dmem_req", dmem_req, 0);
        chk("timeout in_ready", in_ready, 1);
        chk("timeout lsu_res_en", lsu_res_en, 0);
        @(negedge clk);
        chk("timeout bus_err_drop", bus_err_o, 0);
        run_vec(vecs[0]);

        // Flush while waiting for the response; rvalid three cycles later.
        start_op(LSU_LW, 32'h500, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("flush_resp still_busy", in_ready, 0);
            chk("flush_resp no_req", dmem_req, 0);
            @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11223344;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("flush_resp lsu_res_en", lsu_res_en, 0);
        chk("flush_resp rd_en_o", rd_en_o, 0);
        chk("flush_resp in_ready", in_ready, 1);

        // Reset mid-transaction clears the held writeback fields too.
        run_vec(vecs[0]);
        start_op(LSU_LW, 32'h600, 32'h0, 5'd6, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_resp lsu_res", lsu_res, 0);
        chk("rst_resp rd_addr_o", rd_addr_o, 0);
        chk("rst_resp lsu_res_en", lsu_res_en, 0);
        chk("rst_resp rd_en_o", rd_en_o, 0);
        chk("rst_resp dmem_req", dmem_req, 0);
        chk("rst_resp dmem_we", dmem_we, 0);
        chk("rst_resp dmem_be", dmem_be, 0);
        chk("rst_resp misalign_o", misalign_o, 0);
        chk("rst_resp bus_err_o", bus_err_o, 0);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("late_rvalid lsu_res_en", lsu_res_en, 0);
        chk("late_rvalid lsu_res", lsu_res, 0);
        chk("late_rvalid in_ready", in_ready, 1);

        // Flush before grant abandons the request.
        start_op(LSU_LW, 32'h700, 32'h0, 5'd8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_req req_up", dmem_req, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_req dmem_req", dmem_req, 0);
        chk("flush_req in_ready", in_ready, 1);
        chk("flush_req bus_err_o", bus_err_o, 0);

        // Flush coincident with grant: response still drained, writeback dropped.
        start_op(LSU_LW, 32'h704, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        dmem_gnt = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        dmem_gnt = 1'b0;
        chk("flush_gnt in_resp", in_ready, 0);
        chk("flush_gnt dmem_req", dmem_req, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h00000055;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("flush_gnt lsu_res_en", lsu_res_en, 0);
        chk("flush_gnt in_ready", in_ready, 1);

        // Flush in IDLE blocks acceptance.
        start_op(LSU_LW, 32'h708, 32'h0, 5'd2, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle dmem_req", dmem_req, 0);
        chk("flush_idle in_ready", in_ready, 1);
        @(negedge clk);
        chk("flush_idle lsu_res_en", lsu_res_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 255, bus cycles allowed per access before timeout; XLEN taken from cpu_config, fixed at 32 for this block.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  execute stage presents a memory op.
REQ-005 in_ready  out  1  op accepted when in_valid && in_ready.
REQ-006 in_op  in  lsu_op_t  LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-007 in_addr / in_wdata  in  XLEN  effective byte address / store data (low bytes used).
REQ-008 in_rd_addr  in  rs_addr_t;  in_rd_en  in  1  destination register and write enable.
REQ-009 flush  in  1  cancel the in-flight op's writeback.
REQ-010 dmem_req, dmem_we  out  1;  dmem_addr  out  XLEN (word aligned);  dmem_be  out  XLEN/8;  dmem_wdata  out  XLEN.
REQ-011 dmem_gnt, dmem_rvalid, dmem_err  in  1;  dmem_rdata  in  XLEN.
REQ-012 lsu_res  out  XLEN;  lsu_res_en  out  1;  rd_addr_o  out  rs_addr_t;  rd_en_o  out  1  to writeback.
REQ-013 misalign_o, bus_err_o  out  1  single-cycle exception pulses.

Function
REQ-014 FSM states IDLE, REQ, RESP; in_ready = (state == IDLE) && !rst.
REQ-015 IDLE: on accept of an aligned op, latch op, addr, rd, lanes, data; go to REQ next cycle.
REQ-016 Alignment: H ops need addr[0]=0, W ops need addr[1:0]=0; violation pulses misalign_o the next cycle, issues no bus request, produces no lsu_res_en, stays IDLE.
REQ-017 REQ: dmem_req=1, dmem_addr={addr[31:2],2'b00}; on dmem_gnt go to RESP; request fields stay stable until gnt.
REQ-018 Byte enables: B=4'b0001<<addr[1:0], H=4'b0011<<addr[1:0], W=4'b1111; store data replicated into lanes (SB: {4{b}}, SH: {2{h}}); loads drive dmem_we=0 with be as computed.
REQ-019 RESP: on dmem_rvalid go to IDLE; for loads, register extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU, LW unchanged.
REQ-020 lsu_res_en pulses exactly one cycle after the rvalid cycle, only for loads with latched rd_en=1 and rd!=0 and no flush since accept; rd_addr_o/rd_en_o valid in the same cycle; otherwise lsu_res_en, rd_en_o=0.
REQ-021 Stores never assert lsu_res_en; store completion is the rvalid ack.
REQ-022 Minimum load latency: accept cycle N, dmem_req N+1 (gnt same cycle), rvalid N+2, lsu_res_en N+3.
REQ-023 dmem_err sampled with rvalid: bus_err_o pulses next cycle, lsu_res_en suppressed.
REQ-024 Wait counter clears on entering REQ, increments each cycle in REQ/RESP; reaching MAX_WAIT forces IDLE, drops dmem_req, pulses bus_err_o.
REQ-025 flush in REQ before gnt: drop dmem_req next cycle, return IDLE; flush coincident with gnt: treated as granted, go to RESP, suppress writeback.
REQ-026 flush in RESP: keep waiting for rvalid (no orphaned response), suppress writeback; flush in IDLE with in_valid: op not accepted.

Reset
REQ-027 rst forces state IDLE, counter 0, all outputs 0 (dmem_req, dmem_we, dmem_be, lsu_res, lsu_res_en, rd_addr_o, rd_en_o, misalign_o, bus_err_o) by the following edge, including mid-transaction; a late rvalid after reset is ignored in IDLE.

Structure
REQ-028 lsu_op_t and the state enum live in cpu_types; XLEN in cpu_config; rs_addr_t in riscv_types.
REQ-029 One combinational sub-module, lsu_load_align (rdata, byte offset, op -> extended result), instantiated once.

Verification
REQ-030 LW addr 0x100, gnt immediate, rvalid next cycle rdata 0xDEADBEEF, rd=5 -> lsu_res=0xDEADBEEF, lsu_res_en one cycle at N+3, rd_addr_o=5.
REQ-031 LB addr 0x103, rdata 0x80FF_0000 -> be=4'b1000, lsu_res=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x202, data 0x1234 -> dmem_we=1, be=4'b1100, wdata=0x12341234, no lsu_res_en.
REQ-033 LW addr 0x101 -> misalign_o pulse, dmem_req never asserted, in_ready stays 1.
REQ-034 LW with gnt held low 255 cycles (MAX_WAIT=255) -> bus_err_o pulse, dmem_req drops, next op accepted.
REQ-035 LW granted, flush in RESP, rvalid 3 cycles later -> no lsu_res_en; rst asserted in RESP -> all outputs 0 next cycle.
